clk_mon_axil_slave: RTL and testbench
=====================================

Name: clk_mon_axil_slave

Overview:
AXI4-Lite responder for the clk_mon block; it terminates the transactions that the AXI master issues.
- Holds the clk_mon register file: control, gate length, measured count and scratch.
- Contains a gated event counter. It counts pulses on a pre-synchronised tick input over a programmable window of ACLK cycles.
- Sits between the PS AXI interconnect and the clock-monitor front end.

Parameters:
- C_S_AXI_ADDR_WIDTH, 4: address width. Only ADDR[3:2] is decoded when the value is 4.
- C_S_AXI_DATA_WIDTH, 32: data width, fixed at 32. Any other value is unsupported.
- RESET_GATE, 32'd1000: reset value of the GATE register.

Ports:
- ACLK  in  1  single clock
- ARESET  in  1  asynchronous, active-high reset
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID  in  1
- S_AXI_AWREADY  out  1
- S_AXI_WDATA  in  32
- S_AXI_WSTRB  in  4  byte enables
- S_AXI_WVALID  in  1
- S_AXI_WREADY  out  1
- S_AXI_BRESP  out  2
- S_AXI_BVALID  out  1
- S_AXI_BREADY  in  1
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID  in  1
- S_AXI_ARREADY  out  1
- S_AXI_RDATA  out  32
- S_AXI_RRESP  out  2
- S_AXI_RVALID  out  1
- S_AXI_RREADY  in  1
- evt_tick  in  1  single-cycle event pulse, already synchronous to ACLK
- meas_done  out  1  one-cycle pulse when a window completes

Behaviour:
- Reset (asynchronous, ARESET=1):
  - AWREADY=WREADY=ARREADY=1; BVALID=RVALID=0; BRESP=RRESP=0; RDATA=0; meas_done=0.
  - CTRL=0, GATE=RESET_GATE, COUNT=0, SCRATCH=0; internal counters 0.
  - Deassertion takes effect on the first ACLK edge after release.
  - Reset mid-transaction aborts it; no response is issued.
- Register map (byte address):
  - 0x00 CTRL RW. bit0 EN. bit1 CLR, write-1 self-clearing, always reads 0. Other bits read 0.
  - 0x04 GATE RW, 32 bits, window length in ACLK cycles.
  - 0x08 COUNT RO. Writes are ignored and answered OKAY.
  - 0x0C SCRATCH RW, 32 bits.
- Write path:
  - AW and W are accepted independently, in either order or in the same cycle.
  - Each READY drops after its own handshake and stays low until the B handshake completes.
  - The cycle after both are held: the register updates per WSTRB byte lanes, and BVALID=1 with BRESP=OKAY.
  - BVALID holds until BREADY. AWREADY/WREADY re-assert the cycle after the B handshake.
  - Only one write is outstanding at a time.
- Read path:
  - After the AR handshake, ARREADY=0. Next cycle RDATA is registered and RVALID=1, RRESP=OKAY.
  - RDATA/RVALID hold stable until RREADY. ARREADY re-asserts the cycle after the R handshake.
- Simultaneous read and write to the same register: the read returns the pre-write value.
- Measurement:
  - With EN=1 and GATE!=0, GATE is latched at window start. The gate counter runs 0..GATE-1.
  - The event counter adds 1 per evt_tick and saturates at 0xFFFFFFFF.
  - On the last window cycle: COUNT <= event count, including a tick in that cycle. The event counter restarts at 0 (1 if a tick is present on the first cycle of the new window). meas_done=1 for one cycle.
  - Windows run back-to-back without gaps.
  - GATE=0: no windows run and the counters are held at 0.
  - A GATE write mid-window takes effect at the next window start.
  - EN falling: counters clear and COUNT is retained. EN rising: a window starts on the next cycle.
  - CLR write: COUNT and both counters go to 0 the next cycle and the window restarts. CLR wins over a simultaneous window end.

Optional Feature:
- Macro: CLK_MON_SLVERR_EN.
- Defined:
  - Accesses whose address bits above [3:2] are nonzero (only possible when C_S_AXI_ADDR_WIDTH>4) get BRESP/RRESP=SLVERR (2'b10).
  - For such accesses, writes have no effect and RDATA=0.
  - Writes to COUNT also return SLVERR.
- Undefined: upper address bits are ignored (the register map aliases), and all responses are OKAY.

Test Plan:
- Write 1,2,3,4 to 0x00..0x0C with WSTRB=0xF, then read back -> CTRL reads 0x1, GATE 0x2, COUNT 0x0 (write ignored), SCRATCH 0x4.
- W presented 3 cycles before AW to 0x0C with data 0xA5A5A5A5 and WSTRB=0x3 -> BVALID exactly 1 cycle after the AW handshake; SCRATCH=0x0000A5A5; BRESP=OKAY.
- Hold BREADY=0 for 5 cycles, and RREADY=0 for 5 cycles on a read -> BVALID/RVALID and RDATA stable; no new AW/AR accepted until the respective handshake.
- GATE=10, EN=1, evt_tick every 2nd cycle -> meas_done every 10 cycles; COUNT=5 after each window.
- Mid-window CLR write in the same cycle as a window end -> COUNT=0; next meas_done 10 cycles after the CLR.
- CLK_MON_SLVERR_EN with C_S_AXI_ADDR_WIDTH=8: write and read 0x10 -> SLVERR, RDATA=0, SCRATCH unchanged. Without the macro -> aliases CTRL, OKAY.

Source files
------------

// File: rtl/clk_mon_axil_slave.sv
// AXI4-Lite register slave for the clock monitor: CTRL/GATE/COUNT/SCRATCH plus a gated event counter.
// Optional macro CLK_MON_SLVERR_EN: SLVERR for out-of-map addresses and COUNT writes.
module clk_mon_axil_slave #(
  parameter int          C_S_AXI_ADDR_WIDTH = 4,
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter logic [31:0] RESET_GATE         = 32'd1000
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [3:0]                      S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic                            evt_tick,
  output logic                            meas_done
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_GATE    = 2'd1;
  localparam logic [1:0] REG_COUNT   = 2'd2;

  logic                          aw_held, w_held;
  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr_q;
  logic [31:0]                   wdata_q;
  logic [3:0]                    wstrb_q;

  logic        ctrl_en;
  logic [31:0] gate_reg, count_reg, scratch_reg;
  logic        running;
  logic [31:0] remain, evt_cnt;

  logic        wr_fire, wr_err, rd_err, wr_en, clr_pulse;
  logic [1:0]  wr_idx, rd_idx;
  logic [31:0] rd_mux;
  logic        active, last_cycle;
  logic [31:0] rem_cur, evt_next;

  function automatic logic [31:0] merge_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++)
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    return res;
  endfunction

  assign wr_fire = aw_held && w_held;
  assign wr_idx  = awaddr_q[3:2];
  assign rd_idx  = S_AXI_ARADDR[3:2];

`ifdef CLK_MON_SLVERR_EN
  assign wr_err = ((awaddr_q >> 4) != '0) || (wr_idx == REG_COUNT);
  assign rd_err = (S_AXI_ARADDR >> 4) != '0;
`else
  assign wr_err = 1'b0;
  assign rd_err = 1'b0;
`endif

  assign wr_en     = wr_fire && !wr_err;
  assign clr_pulse = wr_en && (wr_idx == REG_CTRL) && wstrb_q[0] && wdata_q[1];

  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, awaddr_q, S_AXI_ARADDR};

  // Write channel: AW and W captured independently, one write outstanding.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      S_AXI_AWREADY <= 1'b1;
      S_AXI_WREADY  <= 1'b1;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      awaddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
    end else begin
      if (S_AXI_AWVALID && S_AXI_AWREADY) begin
        S_AXI_AWREADY <= 1'b0;
        aw_held       <= 1'b1;
        awaddr_q      <= S_AXI_AWADDR;
      end
      if (S_AXI_WVALID && S_AXI_WREADY) begin
        S_AXI_WREADY <= 1'b0;
        w_held       <= 1'b1;
        wdata_q      <= S_AXI_WDATA[31:0];
        wstrb_q      <= S_AXI_WSTRB;
      end
      if (wr_fire) begin
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end
      if (S_AXI_BVALID && S_AXI_BREADY) begin
        S_AXI_BVALID  <= 1'b0;
        S_AXI_AWREADY <= 1'b1;
        S_AXI_WREADY  <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_mux = scratch_reg;
    case (rd_idx)
      REG_CTRL:  rd_mux = {31'd0, ctrl_en};
      REG_GATE:  rd_mux = gate_reg;
      REG_COUNT: rd_mux = count_reg;
      default:   rd_mux = scratch_reg;
    endcase
  end

  // Read data is sampled at the AR handshake, so a same-edge write is not visible.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      S_AXI_ARREADY <= 1'b1;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RRESP   <= RESP_OKAY;
      S_AXI_RDATA   <= '0;
    end else begin
      if (S_AXI_ARVALID && S_AXI_ARREADY) begin
        S_AXI_ARREADY <= 1'b0;
        S_AXI_RVALID  <= 1'b1;
        S_AXI_RRESP   <= rd_err ? RESP_SLVERR : RESP_OKAY;
        S_AXI_RDATA   <= rd_err ? '0 : rd_mux;
      end
      if (S_AXI_RVALID && S_AXI_RREADY) begin
        S_AXI_RVALID  <= 1'b0;
        S_AXI_ARREADY <= 1'b1;
      end
    end
  end

  // When idle the window length comes straight from GATE; remain holds it once running.
  always_comb begin
    rem_cur    = running ? remain : (gate_reg - 32'd1);
    active     = ctrl_en && (running || (gate_reg != 32'd0));
    last_cycle = active && (rem_cur == 32'd0);
    evt_next   = (evt_tick && (evt_cnt != 32'hFFFF_FFFF)) ? (evt_cnt + 32'd1) : evt_cnt;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      ctrl_en     <= 1'b0;
      gate_reg    <= RESET_GATE;
      count_reg   <= '0;
      scratch_reg <= '0;
      running     <= 1'b0;
      remain      <= '0;
      evt_cnt     <= '0;
      meas_done   <= 1'b0;
    end else begin
      meas_done <= 1'b0;
      if (wr_en) begin
        case (wr_idx)
          REG_CTRL:  if (wstrb_q[0]) ctrl_en <= wdata_q[0];
          REG_GATE:  gate_reg <= merge_strb(gate_reg, wdata_q, wstrb_q);
          REG_COUNT: ;
          default:   scratch_reg <= merge_strb(scratch_reg, wdata_q, wstrb_q);
        endcase
      end
      if (clr_pulse) begin
        count_reg <= '0;
        running   <= 1'b0;
        remain    <= '0;
        evt_cnt   <= '0;
      end else if (!active) begin
        running <= 1'b0;
        remain  <= '0;
        evt_cnt <= '0;
      end else if (last_cycle) begin
        count_reg <= evt_next;
        meas_done <= 1'b1;
        running   <= 1'b0;
        remain    <= '0;
        evt_cnt   <= '0;
      end else begin
        running <= 1'b1;
        remain  <= rem_cur - 32'd1;
        evt_cnt <= evt_next;
      end
    end
  end

endmodule

// File: tb/tb_clk_mon_axil_slave.sv
// Scoreboard bench for clk_mon_axil_slave: B/R responses checked by a monitor against queued expectations.
`timescale 1ns/1ps
module tb_clk_mon_axil_slave;
  localparam int AW = 8;
`ifdef CLK_MON_SLVERR_EN
  localparam bit SLV = 1'b1;
`else
  localparam bit SLV = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] awaddr = '0;
  logic [2:0]    awprot = 3'd0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [31:0]   wdata = '0;
  logic [3:0]    wstrb = 4'h0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b1;
  logic [AW-1:0] araddr = '0;
  logic [2:0]    arprot = 3'd0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready = 1'b1;
  logic          evt_tick = 1'b0;
  logic          meas_done;

  always #5 clk = ~clk;

  clk_mon_axil_slave #(
    .C_S_AXI_ADDR_WIDTH(AW),
    .C_S_AXI_DATA_WIDTH(32),
    .RESET_GATE(32'd1000)
  ) dut (
    .ACLK(clk), .ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .evt_tick(evt_tick), .meas_done(meas_done)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit tick_en = 1'b0;

  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];
  logic [1:0]  eb;
  logic [33:0] er;

  always @(posedge clk) cyc <= cyc + 1;

  // Ticks on every second cycle, so a 10-cycle window always holds 5.
  always @(posedge clk) begin
    #1;
    evt_tick = tick_en ? ~evt_tick : 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic fail_msg(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=handshake", name);
  endtask

  always @(negedge clk) begin
    if (!rst && bvalid && bready) begin
      if (exp_b.size() == 0) fail_msg("b_unexpected");
      else begin
        eb = exp_b.pop_front();
        chk("bresp", {30'd0, bresp}, {30'd0, eb});
      end
    end
    if (!rst && rvalid && rready) begin
      if (exp_r.size() == 0) fail_msg("r_unexpected");
      else begin
        er = exp_r.pop_front();
        chk("rdata", rdata, er[31:0]);
        chk("rresp", {30'd0, rresp}, {30'd0, er[33:32]});
      end
    end
  end

  task automatic wait_bdone();
    bit done = 1'b0;
    int n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      done = bvalid && bready;
      @(posedge clk); #1;
      n++;
    end
    if (!done) fail_msg("b_handshake");
  endtask

  task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] resp, input bit wait_b);
    bit aw_done = 1'b0, w_done = 1'b0, a_hs, w_hs;
    int n = 0;
    exp_b.push_back(resp);
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      @(negedge clk);
      a_hs = awvalid && awready;
      w_hs = wvalid && wready;
      @(posedge clk); #1;
      if (a_hs) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (w_hs) begin wvalid = 1'b0; w_done = 1'b1; end
      n++;
    end
    if (!(aw_done && w_done)) begin
      fail_msg("aw_w_handshake");
      awvalid = 1'b0; wvalid = 1'b0;
    end
    if (wait_b) wait_bdone();
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input logic [31:0] data,
                          input logic [1:0] resp, input bit wait_r);
    bit done = 1'b0, hs;
    int n = 0;
    exp_r.push_back({resp, data});
    araddr = addr; arvalid = 1'b1;
    while (!done && n < 20) begin
      @(negedge clk);
      hs = arvalid && arready;
      @(posedge clk); #1;
      if (hs) begin arvalid = 1'b0; done = 1'b1; end
      n++;
    end
    if (!done) begin fail_msg("ar_handshake"); arvalid = 1'b0; end
    if (wait_r) begin
      done = 1'b0; n = 0;
      while (!done && n < 20) begin
        @(negedge clk);
        done = rvalid && rready;
        @(posedge clk); #1;
        n++;
      end
      if (!done) fail_msg("r_handshake");
    end
  endtask

  task automatic wait_md(output int c);
    bit seen = 1'b0;
    int n = 0;
    c = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      if (meas_done) begin seen = 1'b1; c = cyc; end
      n++;
    end
    if (!seen) fail_msg("meas_done_wait");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, md_cnt;
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_awready", {31'd0, awready}, 32'd1);
    chk("rst_wready", {31'd0, wready}, 32'd1);
    chk("rst_arready", {31'd0, arready}, 32'd1);
    chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_meas_done", {31'd0, meas_done}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    axi_read(8'h04, 32'd1000, 2'b00, 1'b1);

    // Basic map: COUNT ignores writes
    axi_write(8'h00, 32'd1, 4'hF, 2'b00, 1'b1);
    axi_write(8'h04, 32'd2, 4'hF, 2'b00, 1'b1);
    axi_write(8'h08, 32'd3, 4'hF, SLV ? 2'b10 : 2'b00, 1'b1);
    axi_write(8'h0C, 32'd4, 4'hF, 2'b00, 1'b1);
    axi_read(8'h00, 32'd1, 2'b00, 1'b1);
    axi_read(8'h04, 32'd2, 2'b00, 1'b1);
    axi_read(8'h08, 32'd0, 2'b00, 1'b1);
    axi_read(8'h0C, 32'd4, 2'b00, 1'b1);
    axi_write(8'h00, 32'd0, 4'hF, 2'b00, 1'b1);

    // W three cycles ahead of AW, partial strobe
    exp_b.push_back(2'b00);
    wdata = 32'hA5A5A5A5; wstrb = 4'h3; wvalid = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0;
    @(negedge clk);
    chk("wready_low_after_w", {31'd0, wready}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    awaddr = 8'h0C; awvalid = 1'b1;
    @(negedge clk);
    chk("awready_before_aw", {31'd0, awready}, 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    @(negedge clk);
    chk("bvalid_at_aw_hs", {31'd0, bvalid}, 32'd0);
    @(negedge clk);
    chk("bvalid_1_after_aw", {31'd0, bvalid}, 32'd1);
    @(posedge clk); #1;
    axi_read(8'h0C, 32'h0000A5A5, 2'b00, 1'b1);

    // B stall with a competing AW
    bready = 1'b0;
    axi_write(8'h0C, 32'h12345678, 4'hF, 2'b00, 1'b0);
    awaddr = 8'h04; awvalid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("b_stall_bvalid", {31'd0, bvalid}, 32'd1);
      chk("b_stall_awready", {31'd0, awready}, 32'd0);
      chk("b_stall_wready", {31'd0, wready}, 32'd0);
    end
    @(posedge clk); #1;
    awvalid = 1'b0; bready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("awready_after_b", {31'd0, awready}, 32'd1);
    @(posedge clk); #1;

    // R stall with a competing AR
    rready = 1'b0;
    axi_read(8'h0C, 32'h12345678, 2'b00, 1'b0);
    araddr = 8'h00; arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("r_stall_rvalid", {31'd0, rvalid}, 32'd1);
      chk("r_stall_rdata", rdata, 32'h12345678);
      chk("r_stall_arready", {31'd0, arready}, 32'd0);
    end
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("arready_after_r", {31'd0, arready}, 32'd1);
    @(posedge clk); #1;

    // Measurement windows of 10 cycles
    axi_write(8'h04, 32'd10, 4'hF, 2'b00, 1'b1);
    tick_en = 1'b1;
    axi_write(8'h00, 32'd1, 4'hF, 2'b00, 1'b1);
    wait_md(c0);
    for (int i = 0; i < 3; i++) begin
      wait_md(c1);
      chk("meas_period", c1 - c0, 32'd10);
      c0 = c1;
    end
    @(posedge clk); #1;
    axi_read(8'h08, 32'd5, 2'b00, 1'b1);

    // CLR landing on a window end
    wait_md(c0);
    repeat (8) @(posedge clk);
    #1;
    exp_b.push_back(2'b00);
    awaddr = 8'h00; wdata = 32'd3; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    chk("clr_aw_ready", {31'd0, awready & wready}, 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("clr_suppresses_done", {31'd0, meas_done}, 32'd0);
    chk("clr_bvalid", {31'd0, bvalid}, 32'd1);
    @(posedge clk); #1;
    axi_read(8'h08, 32'd0, 2'b00, 1'b1);
    axi_read(8'h00, 32'd1, 2'b00, 1'b1);
    wait_md(c1);
    chk("meas_after_clr", c1 - c0, 32'd20);
    @(posedge clk); #1;
    axi_read(8'h08, 32'd5, 2'b00, 1'b1);

    // Upper address bits: alias or SLVERR
    axi_write(8'h00, 32'd0, 4'hF, 2'b00, 1'b1);
    axi_write(8'h10, 32'd1, 4'hF, SLV ? 2'b10 : 2'b00, 1'b1);
    axi_read(8'h10, SLV ? 32'd0 : 32'd1, SLV ? 2'b10 : 2'b00, 1'b1);
    axi_read(8'h00, SLV ? 32'd0 : 32'd1, 2'b00, 1'b1);
    axi_read(8'h0C, 32'h12345678, 2'b00, 1'b1);

    // GATE=0: no windows, COUNT retained
    axi_write(8'h00, 32'd0, 4'hF, 2'b00, 1'b1);
    axi_write(8'h04, 32'd0, 4'hF, 2'b00, 1'b1);
    axi_write(8'h00, 32'd1, 4'hF, 2'b00, 1'b1);
    md_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (meas_done) md_cnt++;
    end
    chk("gate0_no_windows", md_cnt, 32'd0);
    @(posedge clk); #1;
    axi_read(8'h08, 32'd5, 2'b00, 1'b1);
    tick_en = 1'b0;

    repeat (3) @(posedge clk);
    chk("b_queue_drained", exp_b.size(), 32'd0);
    chk("r_queue_drained", exp_r.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
